// File: rtl/ddr_phase_picker_pkg.sv
// Shared types and defaults for the DDR lane phase picker.
// Optional slip statistics are enabled with DDR_PHASE_PICKER_STATS_EN.
package ddr_phase_picker_pkg;

   localparam int unsigned WINDOW_LOG2_DEF = 4;
   localparam int unsigned MIN_TRANS_DEF   = 4;
   localparam int unsigned MARGIN_DEF      = 2;

   localparam logic PH_0   = 1'b0;
   localparam logic PH_180 = 1'b1;

   localparam logic [7:0] SLIP_COUNT_MAX = 8'hFF;

   typedef enum logic [0:0] {
      ACQ  = 1'b0,
      LOCK = 1'b1
   } state_e;

   // Transition flags seen in one clk period
   typedef struct packed {
      logic trans_a;
      logic trans_b;
   } trans_t;

endpackage

// File: rtl/ddr_phase_picker_edge_window_counter.sv
// Counts rising-edge (a) and falling-edge (b) transitions over a 2^WINDOW_LOG2 window.
// Final counts, including the window-end cycle, are presented with window_end_c.
module ddr_phase_picker_edge_window_counter
   import ddr_phase_picker_pkg::*;
#(
   parameter int unsigned WINDOW_LOG2 = WINDOW_LOG2_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   count_en,
   input  trans_t                 trans,
   output logic                   window_end_c,
   output logic [WINDOW_LOG2:0]   cnt_a_c,
   output logic [WINDOW_LOG2:0]   cnt_b_c
);

   localparam int unsigned CW = WINDOW_LOG2 + 1;

   logic [WINDOW_LOG2-1:0] win_cnt_q;
   logic [CW-1:0]          cnt_a_q;
   logic [CW-1:0]          cnt_b_q;
   logic                   inc_a_c;
   logic                   inc_b_c;

   assign inc_a_c      = count_en & trans.trans_a;
   assign inc_b_c      = count_en & trans.trans_b;
   assign cnt_a_c      = cnt_a_q + CW'(inc_a_c);
   assign cnt_b_c      = cnt_b_q + CW'(inc_b_c);
   assign window_end_c = (win_cnt_q == '1);

   // Extra counter bit means a full window of transitions never wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt_q <= '0;
         cnt_a_q   <= '0;
         cnt_b_q   <= '0;
      end else begin
         win_cnt_q <= win_cnt_q + WINDOW_LOG2'(1);
         if (window_end_c) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
         end else begin
            cnt_a_q <= cnt_a_c;
            cnt_b_q <= cnt_b_c;
         end
      end
   end

endmodule

// File: rtl/ddr_phase_picker.sv
// Per-lane DDR receive stage: picks the in_0 or in_180 sample nearer mid-bit.
// Define DDR_PHASE_PICKER_STATS_EN to add the saturating slip_count output.
module ddr_phase_picker
   import ddr_phase_picker_pkg::*;
#(
   parameter int unsigned WINDOW_LOG2 = WINDOW_LOG2_DEF,
   parameter int unsigned MIN_TRANS   = MIN_TRANS_DEF,
   parameter int unsigned MARGIN      = MARGIN_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_0,
   input  logic       in_180,
   output logic       data_out,
   output logic       data_valid,
   output logic       phase_sel,
   output logic       lock,
   output logic       slip
`ifdef DDR_PHASE_PICKER_STATS_EN
   ,
   output logic [7:0] slip_count
`endif
);

   localparam int unsigned CW = WINDOW_LOG2 + 1;
   localparam logic [0:0] ST_ACQ  = 1'(ACQ);
   localparam logic [0:0] ST_LOCK = 1'(LOCK);

   logic          d0_q;
   logic          d180_q;
   logic          p180_q;
   logic [1:0]    prime_q;
   logic [0:0]    state_q;
   logic [0:0]    state_d;
   logic          phase_d;
   logic          lock_d;
   logic          slip_d;
   trans_t        trans_c;
   logic          window_end_c;
   logic [CW-1:0] cnt_a_c;
   logic [CW-1:0] cnt_b_c;
   logic [31:0]   ext_a_c;
   logic [31:0]   ext_b_c;
   logic          low_act_c;
   logic          a_wins_c;
   logic          b_wins_c;

   assign trans_c.trans_a = p180_q ^ d0_q;
   assign trans_c.trans_b = d0_q ^ d180_q;

   ddr_phase_picker_edge_window_counter #(
      .WINDOW_LOG2 (WINDOW_LOG2)
   ) u_win (
      .clk          (clk),
      .rst          (rst),
      .count_en     (prime_q[1]),
      .trans        (trans_c),
      .window_end_c (window_end_c),
      .cnt_a_c      (cnt_a_c),
      .cnt_b_c      (cnt_b_c)
   );

   assign ext_a_c   = 32'(cnt_a_c);
   assign ext_b_c   = 32'(cnt_b_c);
   assign low_act_c = (ext_a_c + ext_b_c) < MIN_TRANS;
   assign a_wins_c  = ext_a_c > (ext_b_c + MARGIN);
   assign b_wins_c  = ext_b_c > (ext_a_c + MARGIN);

   // Decision logic: acquire once, then move only on a clear majority
   always_comb begin
      state_d = state_q;
      phase_d = phase_sel;
      lock_d  = lock;
      slip_d  = 1'b0;
      if (window_end_c && !low_act_c) begin
         case (state_q)
            ST_ACQ: begin
               phase_d = (cnt_a_c >= cnt_b_c) ? PH_180 : PH_0;
               lock_d  = 1'b1;
               state_d = ST_LOCK;
            end
            ST_LOCK: begin
               if (phase_sel == PH_180 && b_wins_c) begin
                  phase_d = PH_0;
                  slip_d  = 1'b1;
               end else if (phase_sel == PH_0 && a_wins_c) begin
                  phase_d = PH_180;
                  slip_d  = 1'b1;
               end
            end
            default: state_d = ST_ACQ;
         endcase
      end
   end

   // Prime waits until p180_q holds real data before counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d0_q       <= 1'b0;
         d180_q     <= 1'b0;
         p180_q     <= 1'b0;
         prime_q    <= 2'b00;
         state_q    <= ST_ACQ;
         phase_sel  <= PH_180;
         lock       <= 1'b0;
         slip       <= 1'b0;
         data_out   <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         d0_q       <= in_0;
         d180_q     <= in_180;
         p180_q     <= d180_q;
         prime_q    <= {prime_q[0], 1'b1};
         state_q    <= state_d;
         phase_sel  <= phase_d;
         lock       <= lock_d;
         slip       <= slip_d;
         data_out   <= (phase_sel == PH_180) ? d180_q : d0_q;
         data_valid <= lock_d & ~slip_d;
      end
   end

`ifdef DDR_PHASE_PICKER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slip_count <= 8'd0;
      end else if (slip_d && slip_count != SLIP_COUNT_MAX) begin
         slip_count <= slip_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddr_phase_picker.sv
// Directed bench for ddr_phase_picker: per-window transition counts with a planned outcome,
// a data scoreboard fed by the stimulus and a negedge monitor that checks everything.
module tb_ddr_phase_picker;

   localparam int WINDOW = 16;

   logic clk = 1'b0;
   logic rst;
   logic in_0;
   logic in_180;
   logic data_out;
   logic data_valid;
   logic phase_sel;
   logic lock;
   logic slip;
`ifdef DDR_PHASE_PICKER_STATS_EN
   logic [7:0] slip_count;
`endif

   always #5 clk = ~clk;

   ddr_phase_picker dut (
      .clk        (clk),
      .rst        (rst),
      .in_0       (in_0),
      .in_180     (in_180),
      .data_out   (data_out),
      .data_valid (data_valid),
      .phase_sel  (phase_sel),
      .lock       (lock),
      .slip       (slip)
`ifdef DDR_PHASE_PICKER_STATS_EN
      ,
      .slip_count (slip_count)
`endif
   );

   // na/nb: transitions placed in the window; lock/phase/slip: hand-derived outcome at its end
   typedef struct {
      int na;
      int nb;
      bit lock;
      bit phase;
      bit slip;
   } win_t;

   win_t plan[$];
   bit   exp_q[$];
   int   tests;
   int   fails;
   int   t;
   bit   mon_en;
   bit   prev180;

   always @(posedge clk or posedge rst) begin
      if (rst) t <= 0;
      else     t <= t + 1;
   end

   function automatic int plan_idx(input int tt);
      int w;
      w = tt / WINDOW;
      if (w > plan.size()) w = plan.size();
      return w - 1;
   endfunction

   function automatic bit lock_at(input int tt);
      int idx;
      idx = plan_idx(tt);
      return (idx < 0) ? 1'b0 : plan[idx].lock;
   endfunction

   function automatic bit phase_at(input int tt);
      int idx;
      idx = plan_idx(tt);
      return (idx < 0) ? 1'b1 : plan[idx].phase;
   endfunction

   function automatic bit slip_at(input int tt);
      if (tt <= 0 || (tt % WINDOW) != 0 || plan_idx(tt) < 0) return 1'b0;
      return plan[plan_idx(tt)].slip;
   endfunction

   function automatic bit valid_at(input int tt);
      return lock_at(tt) & ~slip_at(tt);
   endfunction

   function automatic int slips_upto(input int tt);
      int n;
      n = 0;
      for (int i = 0; i <= plan_idx(tt); i++) if (plan[i].slip) n++;
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0d actual=%0d expected=%0d", name, t, act, exp);
      end
   endtask

   task automatic add_win(input int na, input int nb, input bit lk, input bit ph, input bit sl);
      win_t w;
      w.na = na; w.nb = nb; w.lock = lk; w.phase = ph; w.slip = sl;
      plan.push_back(w);
   endtask

   // Drive inputs registered at edges k of window w; expected data goes to the scoreboard
   task automatic drive_window(input int w, input int na, input int nb, input int ncyc);
      int lo;
      int hi;
      int i;
      bit ta;
      bit tb;
      lo = (w == 1) ? 1 : WINDOW * (w - 1);
      hi = WINDOW * w - 1;
      if (lo + ncyc - 1 < hi) hi = lo + ncyc - 1;
      for (int k = lo; k <= hi; k++) begin
         i  = k % WINDOW;
         ta = (i >= WINDOW - na);
         tb = (i >= WINDOW - nb);
         in_0    = prev180 ^ ta;
         in_180  = in_0 ^ tb;
         prev180 = in_180;
         if (valid_at(k + 1)) exp_q.push_back(phase_at(k) ? in_180 : in_0);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_plan();
      for (int w = 1; w <= plan.size(); w++) drive_window(w, plan[w-1].na, plan[w-1].nb, WINDOW);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_data_out"},   data_out,   0);
      check({tag, "_data_valid"}, data_valid, 0);
      check({tag, "_phase_sel"},  phase_sel,  1);
      check({tag, "_lock"},       lock,       0);
      check({tag, "_slip"},       slip,       0);
`ifdef DDR_PHASE_PICKER_STATS_EN
      check({tag, "_slip_count"}, slip_count, 0);
`endif
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         check("lock",       lock,       lock_at(t));
         check("phase_sel",  phase_sel,  phase_at(t));
         check("slip",       slip,       slip_at(t));
         check("data_valid", data_valid, valid_at(t));
`ifdef DDR_PHASE_PICKER_STATS_EN
         check("slip_count", slip_count, slips_upto(t));
`endif
         if (data_valid) begin
            if (exp_q.size() == 0) check("sb_unexpected_valid", 32'(exp_q.size()), 1);
            else                   check("data_out", data_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout t=%0d", t);
      $fatal(1, "timeout");
   end

   initial begin
      tests = 0; fails = 0; mon_en = 1'b0;
      rst = 1'b1; in_0 = 1'b0; in_180 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("por");

      // Idle, sub-threshold, lock to 180, slips both ways, hysteresis boundaries, idle hold
      add_win(0, 0, 0, 1, 0);
      add_win(0, 0, 0, 1, 0);
      add_win(0, 0, 0, 1, 0);
      add_win(2, 1, 0, 1, 0);
      add_win(16, 0, 1, 1, 0);
      add_win(16, 0, 1, 1, 0);
      add_win(0, 16, 1, 0, 1);
      add_win(0, 16, 1, 0, 0);
      add_win(16, 0, 1, 1, 1);
      add_win(8, 10, 1, 1, 0);
      add_win(6, 10, 1, 0, 1);
      add_win(2, 2, 1, 0, 0);
      add_win(5, 3, 1, 0, 0);
      add_win(6, 3, 1, 1, 1);
      add_win(3, 0, 1, 1, 0);

      prev180 = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      run_plan();
      drive_window(16, 16, 0, 5);

      // Mid-window reset while locked: outputs clear without a clock edge
      #2 rst = 1'b1;
      #1;
      check_reset_values("async");
      exp_q.delete();
      plan.delete();

      // Spurious first trans_a would push window 1 to the threshold
      add_win(1, 2, 0, 1, 0);
      add_win(3, 1, 1, 1, 0);
      add_win(0, 16, 1, 0, 1);
      add_win(0, 0, 1, 0, 0);

      repeat (2) @(posedge clk);
      prev180 = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      run_plan();
      @(posedge clk);
      @(negedge clk);
      #1 mon_en = 1'b0;
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
